// File: rtl/btb_update_sched_pkg.sv
// Shared BTB write-scheduler types: geometry constants, update payload, FSM states.
package btb_update_sched_pkg;

  localparam int unsigned BTB_num_rows = 256;
  localparam int unsigned BTB_IDX_W    = 8;
  localparam int unsigned BTB_PC_W     = 16;

  typedef struct packed {
    logic [BTB_PC_W-1:0] pc;
    logic                taken;
    logic [BTB_PC_W-1:0] target;
  } btb_upd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } sched_state_e;

endpackage

// File: rtl/btb_update_sched_fifo.sv
// Update FIFO for the BTB write scheduler: push/pop/clear, occupancy and head.
// BTB_UPD_COALESCE_EN adds an index-match search and in-place overwrite of the youngest match.
module btb_upd_fifo
  import btb_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = BTB_IDX_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  btb_upd_t         push_data,
  input  logic             pop,
  input  logic             clear,
`ifdef BTB_UPD_COALESCE_EN
  input  logic             ovr,
  output logic             match_any,
`endif
  output logic [CNT_W-1:0] count,
  output btb_upd_t         head
);

  btb_upd_t         mem_q [DEPTH];
  btb_upd_t         mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

`ifdef BTB_UPD_COALESCE_EN
  logic [PTR_W-1:0] match_slot;
  logic [PTR_W-1:0] slot_c;

  // Walk entries oldest to youngest so the last hit is the youngest; the popping head is excluded.
  always_comb begin
    match_any  = 1'b0;
    match_slot = '0;
    slot_c     = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      slot_c = rd_ptr_q + PTR_W'(k);
      if ((k < int'(count_q)) && !(k == 0 && pop) &&
          (mem_q[slot_c].pc[IDX_W-1:0] == push_data.pc[IDX_W-1:0])) begin
        match_any  = 1'b1;
        match_slot = slot_c;
      end
    end
  end
`endif

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
`ifdef BTB_UPD_COALESCE_EN
      if (ovr) begin
        mem_d[match_slot] = push_data;
      end
`endif
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/btb_update_sched.sv
// Schedules BTB write-port traffic: queued Execute updates with bounded fetch-conflict deferral,
// plus a row-per-cycle flush sequencer. BTB_UPD_COALESCE_EN merges same-index queued updates.
module btb_update_sched
  import btb_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_DEFER = 4,
  parameter int unsigned NUM_ROWS  = BTB_num_rows,
  parameter int unsigned IDX_W     = BTB_IDX_W,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [BTB_PC_W-1:0] ex_pc,
  input  logic                ex_taken,
  input  logic [BTB_PC_W-1:0] ex_target,
  input  logic                fetch_valid,
  input  logic [BTB_PC_W-1:0] fetch_pc,
  input  logic                flush_req,
  output logic                btb_wr,
  output logic [BTB_PC_W-1:0] btb_w_pc,
  output logic                btb_valid,
  output logic [BTB_PC_W-1:0] btb_bt,
  output logic                busy,
  output logic                flush_done,
  output logic [CNT_W-1:0]    q_count
);

  localparam int unsigned DEF_W = $clog2(MAX_DEFER + 1);
  localparam int unsigned ROW_W = $clog2(NUM_ROWS);

  sched_state_e     state_q, state_d;
  logic [DEF_W-1:0] defer_cnt_q, defer_cnt_d;
  logic [ROW_W-1:0] flush_idx_q, flush_idx_d;
  logic             flush_done_q, flush_done_d;

  btb_upd_t head;
  btb_upd_t push_data;
  logic     full_c, conflict_c, defer_c, pop_c, push_c, clear_c, accept_c;
  logic     unused_fetch_hi;

  assign push_data  = '{pc: ex_pc, taken: ex_taken, target: ex_target};
  assign full_c     = (q_count == CNT_W'(DEPTH));
  assign conflict_c = fetch_valid && (fetch_pc[IDX_W-1:0] == head.pc[IDX_W-1:0]);
  assign defer_c    = conflict_c && (defer_cnt_q < DEF_W'(MAX_DEFER));
  assign pop_c      = (state_q == ST_IDLE) && !flush_req && (q_count != '0) && !defer_c;
  assign clear_c    = (state_q == ST_IDLE) && flush_req;
  assign accept_c   = ex_valid && ex_ready;
  assign unused_fetch_hi = ^fetch_pc[BTB_PC_W-1:IDX_W];

`ifdef BTB_UPD_COALESCE_EN
  logic match_any;
  logic ovr_c;

  assign ex_ready = (state_q == ST_IDLE) && !flush_req && (!full_c || match_any);
  assign ovr_c    = accept_c && match_any;
  assign push_c   = accept_c && !match_any;
`else
  assign ex_ready = (state_q == ST_IDLE) && !flush_req && !full_c;
  assign push_c   = accept_c;
`endif

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data),
    .pop       (pop_c),
    .clear     (clear_c),
`ifdef BTB_UPD_COALESCE_EN
    .ovr       (ovr_c),
    .match_any (match_any),
`endif
    .count     (q_count),
    .head      (head)
  );

  // Next state, counters and write-port drive.
  always_comb begin
    state_d      = state_q;
    defer_cnt_d  = defer_cnt_q;
    flush_idx_d  = flush_idx_q;
    flush_done_d = 1'b0;
    btb_wr       = 1'b0;
    btb_w_pc     = '0;
    btb_valid    = 1'b0;
    btb_bt       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
          defer_cnt_d = '0;
        end else if (q_count != '0) begin
          if (defer_c) begin
            defer_cnt_d = defer_cnt_q + DEF_W'(1);
          end else begin
            btb_wr      = 1'b1;
            btb_w_pc    = head.pc;
            btb_valid   = head.taken;
            btb_bt      = head.target;
            defer_cnt_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        btb_wr   = 1'b1;
        btb_w_pc = BTB_PC_W'(flush_idx_q);
        if (flush_req) begin
          flush_idx_d = '0;
        end else if (flush_idx_q == ROW_W'(NUM_ROWS - 1)) begin
          state_d      = ST_IDLE;
          flush_idx_d  = '0;
          flush_done_d = 1'b1;
        end else begin
          flush_idx_d = flush_idx_q + ROW_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      defer_cnt_q  <= '0;
      flush_idx_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      defer_cnt_q  <= defer_cnt_d;
      flush_idx_q  <= flush_idx_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign busy       = (state_q == ST_FLUSH);
  assign flush_done = flush_done_q;

endmodule
